seq_det_ctrl: RTL

Frame sequencer for the Moore sequence-detector FSM. It accepts parallel bit frames over a valid/ready handshake, serializes each frame MSB-first onto the detector's serial input, and gates the detector's enable and reset. It samples the detector's Moore output for every bit it sends and returns a per-frame hit count and a hit-position bitmap over a second valid/ready handshake. It sits between a host/stimulus source and one detector instance, and replaces hand-written per-bit driving.

---
 rtl/seq_det_ctrl.sv | 120 ++++++++++++
 1 files changed

// File: rtl/seq_det_ctrl.sv
// Frame sequencer for a Moore sequence detector. It serializes each accepted
// frame MSB-first onto det_x and gates det_enable/det_reset. It samples det_y one
// cycle after each bit and returns a hit count and a per-bit hit bitmap.
module seq_det_ctrl #(
  parameter int unsigned W  = 16,
  parameter int unsigned CW = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          frame_valid,
  output logic          frame_ready,
  input  logic [W-1:0]  frame_data,
  input  logic [4:0]    frame_len,
  input  logic          clear_det,
  output logic          det_x,
  output logic          det_enable,
  output logic          det_reset,
  input  logic          det_y,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [CW-1:0] res_count,
  output logic [W-1:0]  res_hits
);

  localparam int unsigned LW = 5;

  typedef enum logic [2:0] {StIdle, StClr, StShift, StDrain, StDone} state_e;

  state_e        state_q, state_d;
  logic [W-1:0]  sreg_q, sreg_d;
  logic [W-1:0]  hits_q, hits_d;
  logic [LW-1:0] len_q, len_d;
  logic [LW-1:0] idx_q, idx_d;
  logic [CW-1:0] count_q, count_d;
  logic [LW-1:0] len_clamp;
  logic [LW-1:0] bit_idx;
  logic          sample;

  assign len_clamp = (frame_len > LW'(W)) ? LW'(W) : frame_len;

  // Next-state logic: frame latch, serializer shift and det_y sampling.
  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    hits_d  = hits_q;
    len_d   = len_q;
    idx_d   = idx_q;
    count_d = count_q;
    sample  = 1'b0;
    // det_y seen now belongs to the bit sent in the previous cycle
    bit_idx = idx_q - LW'(1);
    unique case (state_q)
      StIdle: begin
        if (frame_valid) begin
          // Left-align so the first bit to send sits at the MSB
          sreg_d  = frame_data << (LW'(W) - len_clamp);
          len_d   = len_clamp;
          idx_d   = '0;
          count_d = '0;
          hits_d  = '0;
          if (clear_det)              state_d = StClr;
          else if (len_clamp != '0)   state_d = StShift;
          else                        state_d = StDone;
        end
      end
      StClr: begin
        state_d = (len_q != '0) ? StShift : StDone;
      end
      StShift: begin
        sreg_d = sreg_q << 1;
        idx_d  = idx_q + LW'(1);
        sample = (idx_q != '0);
        if (idx_q == len_q - LW'(1)) state_d = StDrain;
      end
      StDrain: begin
        sample  = 1'b1;
        state_d = StDone;
      end
      StDone: begin
        if (res_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (sample && det_y) begin
      hits_d = hits_q | (W'(1) << bit_idx);
      if (count_q != '1) count_d = count_q + CW'(1);
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      sreg_q  <= '0;
      hits_q  <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      hits_q  <= hits_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      count_q <= count_d;
    end
  end

  // Outputs are forced inactive while reset is held; reset passes through to the detector.
  always_comb begin
    frame_ready = ~reset & (state_q == StIdle);
    det_enable  = ~reset & (state_q == StShift);
    det_x       = det_enable & sreg_q[W-1];
    det_reset   = reset | (state_q == StClr);
    res_valid   = ~reset & (state_q == StDone);
    res_count   = reset ? '0 : count_q;
    res_hits    = reset ? '0 : hits_q;
  end

endmodule
